// File: rtl/wb_writeback_stage.sv
// Write-back stage: drives the register-file write port from retiring ALU results and
// from data-memory load responses, with load alignment, timeout and a retire counter.
module wb_writeback_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_flush,
    input  logic [4:0]  in_rd_addr,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_stall,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        reg_write,
    output logic        load_err,
    output logic [31:0] retire_cnt
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off[1], 4'b0000});
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b100:  align_load = {24'd0, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b101:  align_load = {16'd0, h};
            default: align_load = rdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        misaligned = f3[1] ? (off != 2'b00) : (f3[0] & off[0]);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          reg_write_q, reg_write_d;
    logic          load_err_q, load_err_d;
    logic [31:0]   retire_q, retire_d;
    logic [4:0]    ld_rd_q, ld_rd_d;
    logic [2:0]    ld_f3_q, ld_f3_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic          ld_we_q, ld_we_d;
    logic          pend_vld_q, pend_vld_d;
    logic [4:0]    pend_addr_q, pend_addr_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          pend_we_q, pend_we_d;
    logic          accept;
    logic          ld_mis;

    assign wb_stall = (state_q == WAIT_LOAD) & ~dmem_rvalid;
    assign accept   = in_valid & ~in_flush & ~wb_stall;
    assign ld_mis   = misaligned(ld_f3_q, ld_off_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        reg_write_d = 1'b0;
        load_err_d  = 1'b0;
        retire_d    = retire_q + 32'(accept);
        ld_rd_d     = ld_rd_q;
        ld_f3_d     = ld_f3_q;
        ld_off_d    = ld_off_q;
        ld_we_d     = ld_we_q;
        pend_vld_d  = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_we_d   = pend_we_q;

        // Write port owner this edge: load completion first, else a deferred ALU result.
        if (state_q == WAIT_LOAD) begin
            if (dmem_rvalid) begin
                rd_addr_d   = ld_rd_q;
                rd_data_d   = align_load(dmem_rdata, ld_f3_q, ld_off_q);
                reg_write_d = ld_we_q & ~ld_mis;
                load_err_d  = ld_mis;
                state_d     = IDLE;
            end else if (cnt_q == CNT_LAST) begin
                load_err_d = 1'b1;
                state_d    = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pend_vld_q) begin
            rd_addr_d   = pend_addr_q;
            rd_data_d   = pend_data_q;
            reg_write_d = pend_we_q;
        end

        // An ALU op accepted while the port is taken is written one cycle later.
        if (accept) begin
            if (in_mem_read) begin
                ld_rd_d  = in_rd_addr;
                ld_f3_d  = in_funct3;
                ld_off_d = in_alu_result[1:0];
                ld_we_d  = in_reg_write & (in_rd_addr != 5'd0);
                state_d  = WAIT_LOAD;
                cnt_d    = '0;
            end else if ((state_q == WAIT_LOAD) || pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_addr_d = in_rd_addr;
                pend_data_d = in_alu_result;
                pend_we_d   = in_reg_write & (in_rd_addr != 5'd0);
            end else begin
                rd_addr_d   = in_rd_addr;
                rd_data_d   = in_alu_result;
                reg_write_d = in_reg_write & (in_rd_addr != 5'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            reg_write_q <= 1'b0;
            load_err_q  <= 1'b0;
            retire_q    <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            reg_write_q <= reg_write_d;
            load_err_q  <= load_err_d;
            retire_q    <= retire_d;
            pend_vld_q  <= pend_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        ld_rd_q     <= ld_rd_d;
        ld_f3_q     <= ld_f3_d;
        ld_off_q    <= ld_off_d;
        ld_we_q     <= ld_we_d;
        pend_addr_q <= pend_addr_d;
        pend_data_q <= pend_data_d;
        pend_we_q   <= pend_we_d;
    end

    assign rd_addr    = rd_addr_q;
    assign rd_data    = rd_data_q;
    assign reg_write  = reg_write_q;
    assign load_err   = load_err_q;
    assign retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_writeback_stage.sv
// Self-checking bench for wb_writeback_stage: directed scenarios plus a randomized run
// compared against an in-order queue of expected register writes and load errors.
module tb_wb_writeback_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_flush, in_reg_write, in_mem_read;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_stall, reg_write, load_err;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data, retire_cnt;

    int checks = 0;
    int errors = 0;
    int unsigned exp_retire = 0;

    always #5 clk = ~clk;

    wb_writeback_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flush(in_flush),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_stall(wb_stall), .rd_addr(rd_addr), .rd_data(rd_data),
        .reg_write(reg_write), .load_err(load_err), .retire_cnt(retire_cnt)
    );

    task automatic drive_idle();
        in_valid = 0; in_flush = 0; in_rd_addr = 0; in_reg_write = 0; in_mem_read = 0;
        in_funct3 = 0; in_alu_result = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put_alu(input logic [4:0] rd, input logic [31:0] res);
        in_valid = 1; in_flush = 0; in_rd_addr = rd; in_reg_write = 1; in_mem_read = 0;
        in_funct3 = 3'b000; in_alu_result = res;
    endtask

    task automatic put_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
        in_valid = 1; in_flush = 0; in_rd_addr = rd; in_reg_write = 1; in_mem_read = 1;
        in_funct3 = f3; in_alu_result = addr;
    endtask

    // Reference: pick the addressed byte/half with plain arithmetic, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input int off);
        longint unsigned uw, b, h;
        uw = w;
        b = (uw / (64'd1 << (8 * off))) % 256;
        h = (uw / (64'd1 << (16 * (off / 2)))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input int off);
        int size;
        size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        return (off % size) != 0;
    endfunction

    task automatic test_reset();
        drive_idle();
        rst = 0;
        step(); step();
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (reg_write !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got we=%b err=%b want 0 0", reg_write, load_err); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", wb_stall); end
        rst = 1;
        exp_retire = 0;
    endtask

    task automatic test_alu();
        put_alu(5'd5, 32'hDEADBEEF);
        step(); drive_idle();
        exp_retire++;
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", reg_write); end
        checks++; if (rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write got %0d/%h want 5/deadbeef", rd_addr, rd_data); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL alu_retire got %0d want %0d", retire_cnt, exp_retire); end
        step();
        checks++; if (reg_write !== 1'b0 || rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_hold got we=%b data=%h want 0/deadbeef", reg_write, rd_data); end
    endtask

    task automatic test_lb();
        put_load(5'd3, 3'b000, 32'h1000_0002);
        step(); drive_idle(); exp_retire++;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL lb_stall%0d got %b want 1", k, wb_stall); end
            step();
        end
        dmem_rvalid = 1; dmem_rdata = 32'h0080_0000;
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL lb_stall_rvalid got %b want 0", wb_stall); end
        step(); drive_idle();
        checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_write got we=%b rd=%0d data=%h want 1/3/ffffff80", reg_write, rd_addr, rd_data); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL lb_retire got %0d want %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_lhu_lh();
        put_load(5'd4, 3'b101, 32'h2000_0002);
        step(); drive_idle(); exp_retire++;
        dmem_rvalid = 1; dmem_rdata = 32'hABCD1234;
        step(); drive_idle();
        checks++; if (reg_write !== 1'b1 || rd_data !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_write got we=%b data=%h want 1/0000abcd", reg_write, rd_data); end
        put_load(5'd6, 3'b001, 32'h2000_0001);
        step(); drive_idle(); exp_retire++;
        dmem_rvalid = 1; dmem_rdata = 32'hABCD1234;
        step(); drive_idle();
        checks++; if (load_err !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL lh_misalign got err=%b we=%b want 1/0", load_err, reg_write); end
        step();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL lh_err_pulse got %b want 0", load_err); end
    endtask

    task automatic test_rd0_flush();
        put_alu(5'd0, 32'h1234_5678);
        step(); drive_idle(); exp_retire++;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rd0_we got %b want 0", reg_write); end
        put_alu(5'd9, 32'h9999_9999);
        in_flush = 1;
        step(); drive_idle();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", reg_write); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL flush_retire got %0d want %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_timeout();
        put_load(5'd8, 3'b010, 32'h3000_0000);
        step(); drive_idle(); exp_retire++;
        for (int k = 1; k <= TMO; k++) begin
            #1;
            checks++; if (wb_stall !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got stall=%b err=%b want 1/0", k, wb_stall, load_err); end
            step();
        end
        checks++; if (load_err !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL tmo_err got err=%b we=%b want 1/0", load_err, reg_write); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL tmo_stall got %b want 0", wb_stall); end
        put_alu(5'd10, 32'h0000_0055);
        step(); drive_idle(); exp_retire++;
        checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd10 || rd_data !== 32'h55) begin errors++; $display("FAIL tmo_idle got we=%b rd=%0d data=%h want 1/10/55", reg_write, rd_addr, rd_data); end
    endtask

    task automatic test_back_to_back();
        put_load(5'd2, 3'b010, 32'h4000_0004);
        step(); drive_idle(); exp_retire++;
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        put_alu(5'd7, 32'h0000_0077);
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", wb_stall); end
        step(); drive_idle(); exp_retire++;
        checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_load got we=%b rd=%0d data=%h want 1/2/cafef00d", reg_write, rd_addr, rd_data); end
        step();
        checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h77) begin errors++; $display("FAIL b2b_alu got we=%b rd=%0d data=%h want 1/7/77", reg_write, rd_addr, rd_data); end
        step();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", reg_write); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL b2b_retire got %0d want %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_reset_wait();
        put_load(5'd11, 3'b010, 32'h0);
        step(); drive_idle();
        rst = 0;
        step();
        #1;
        checks++; if (rd_addr !== 5'd0 || rd_data !== 32'd0 || reg_write !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL rstw_outputs got rd=%0d data=%h we=%b err=%b want all 0", rd_addr, rd_data, reg_write, load_err); end
        checks++; if (retire_cnt !== 32'd0 || wb_stall !== 1'b0) begin errors++; $display("FAIL rstw_state got retire=%0d stall=%b want 0/0", retire_cnt, wb_stall); end
        rst = 1;
        exp_retire = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h0000_1111;
        step(); drive_idle();
        checks++; if (reg_write !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL rstw_dropped got we=%b err=%b want 0/0", reg_write, load_err); end
    endtask

    task automatic test_random();
        logic [37:0] exp_q[$];
        logic [37:0] act_q[$];
        bit          busy = 0;
        int          waited = 0;
        int          lat = 0;
        logic [4:0]  l_rd = '0;
        logic        l_we = 0;
        logic [2:0]  l_f3 = '0;
        int          l_off = 0;
        int unsigned cnt = exp_retire;
        for (int cyc = 0; cyc < 700; cyc++) begin
            bit rv, stall, acc;
            drive_idle();
            rv = busy && (waited == lat);
            dmem_rdata = $urandom;
            dmem_rvalid = rv || (!busy && $urandom_range(0, 7) == 0);
            stall = busy && !rv;
            if (cyc < 600) begin
                in_valid      = ($urandom_range(0, 3) != 0);
                in_flush      = ($urandom_range(0, 5) == 0);
                in_rd_addr    = 5'($urandom);
                in_reg_write  = 1'($urandom);
                in_mem_read   = ($urandom_range(0, 2) == 0);
                in_funct3     = 3'($urandom);
                in_alu_result = $urandom;
            end
            acc = in_valid && !in_flush && !stall;
            #1;
            checks++; if (wb_stall !== stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", cyc, wb_stall, stall); end
            if (busy) begin
                if (rv) begin
                    if (ref_misaligned(l_f3, l_off)) exp_q.push_back({1'b1, 37'd0});
                    else if (l_we && l_rd != 0) exp_q.push_back({1'b0, l_rd, ref_load(dmem_rdata, l_f3, l_off)});
                    busy = 0;
                end else if (waited == TMO) begin
                    exp_q.push_back({1'b1, 37'd0});
                    busy = 0;
                end else begin
                    waited++;
                end
            end
            if (acc) begin
                cnt++;
                if (in_mem_read) begin
                    busy = 1; waited = 1; lat = $urandom_range(0, 4);
                    l_rd = in_rd_addr; l_we = in_reg_write; l_f3 = in_funct3; l_off = int'(in_alu_result[1:0]);
                end else if (in_reg_write && in_rd_addr != 0) begin
                    exp_q.push_back({1'b0, in_rd_addr, in_alu_result});
                end
            end
            step();
            if (reg_write === 1'b1) act_q.push_back({1'b0, rd_addr, rd_data});
            if (load_err === 1'b1) act_q.push_back({1'b1, 37'd0});
        end
        drive_idle();
        checks++; if (retire_cnt !== cnt) begin errors++; $display("FAIL rnd_retire got %0d want %0d", retire_cnt, cnt); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d events want %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_event %0d got err=%b rd=%0d data=%h want err=%b rd=%0d data=%h", i,
                         act_q[i][37], act_q[i][36:32], act_q[i][31:0], exp_q[i][37], exp_q[i][36:32], exp_q[i][31:0]);
            end
        end
    endtask

    initial begin
        rst = 0;
        drive_idle();
        test_reset();
        test_alu();
        test_lb();
        test_lhu_lh();
        test_rd0_flush();
        test_timeout();
        test_back_to_back();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
